// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
package imem_pkg;

   localparam int unsigned IMEM_ADDR_W = 12;
   localparam int unsigned IMEM_DATA_W = 32;

   typedef enum logic {
      PORT_FETCH = 1'b0,
      PORT_LOAD  = 1'b1
   } port_e;

   typedef struct packed {
      logic                   valid;
      logic [IMEM_DATA_W-1:0] rdata;
   } rsp_slot_t;

endpackage

// File: rtl/imem_rsp_slot.sv
// One-entry registered response slot with valid/ready; capture wins over drain.
module imem_rsp_slot #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture,
   input  logic [DATA_W-1:0] cap_data,
   output logic              can_accept,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata
);

   logic              valid_q;
   logic [DATA_W-1:0] rdata_q;

   // Slot frees up in the same cycle it is drained.
   assign can_accept = !valid_q || rsp_ready;
   assign rsp_valid  = valid_q;
   assign rsp_rdata  = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rdata_q <= '0;
      end else if (capture) begin
         valid_q <= 1'b1;
         rdata_q <= cap_data;
      end else if (valid_q && rsp_ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the instruction memory between fetch (RO) and loader (RW).
// Optional IMEM_ARB_STATS_EN adds saturating conflict / fetch-stall counters.
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W = IMEM_ADDR_W,
   parameter int unsigned DATA_W = IMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req_valid,
   output logic              f_req_ready,
   input  logic [31:0]       f_req_addr,
   output logic              f_rsp_valid,
   input  logic              f_rsp_ready,
   output logic [DATA_W-1:0] f_rsp_rdata,
   input  logic              l_req_valid,
   output logic              l_req_ready,
   input  logic              l_req_we,
   input  logic [31:0]       l_req_addr,
   input  logic [DATA_W-1:0] l_req_wdata,
   output logic              l_rsp_valid,
   input  logic              l_rsp_ready,
   output logic [DATA_W-1:0] l_rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_ARB_STATS_EN
   ,
   output logic [31:0]       conflict_cnt,
   output logic [31:0]       fetch_stall_cnt
`endif
);

   logic              f_can, l_can;
   logic              elig_f, elig_l;
   logic              grant_f, grant_l;
   port_e             last_grant;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [ADDR_W-1:0] f_word, l_word;
   logic [DATA_W-1:0] l_cap_data;
   logic              unused_addr_bits;

   assign f_word = f_req_addr[ADDR_W+1:2];
   assign l_word = l_req_addr[ADDR_W+1:2];
   assign unused_addr_bits = ^{f_req_addr[31:ADDR_W+2], f_req_addr[1:0],
                               l_req_addr[31:ADDR_W+2], l_req_addr[1:0]};

   assign elig_f = f_req_valid && f_can;
   assign elig_l = l_req_valid && l_can;

   always_comb begin
      grant_f = 1'b0;
      grant_l = 1'b0;
      if (rst_n) begin
         if (elig_f && elig_l) begin
            if (last_grant == PORT_LOAD) grant_f = 1'b1;
            else                         grant_l = 1'b1;
         end else begin
            grant_f = elig_f;
            grant_l = elig_l;
         end
      end
   end

   assign f_req_ready = grant_f;
   assign l_req_ready = grant_l;

   always_comb begin
      mem_addr = mem_addr_q;
      if (grant_f)      mem_addr = f_word;
      else if (grant_l) mem_addr = l_word;
   end

   assign mem_we     = grant_l && l_req_we;
   assign mem_wdata  = l_req_wdata;
   assign l_cap_data = l_req_we ? '0 : mem_rdata;

   // Idle cycles keep presenting the last granted address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= PORT_LOAD;
         mem_addr_q <= '0;
      end else begin
         mem_addr_q <= mem_addr;
         if (grant_f)      last_grant <= PORT_FETCH;
         else if (grant_l) last_grant <= PORT_LOAD;
      end
   end

   imem_rsp_slot #(.DATA_W(DATA_W)) u_f_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .capture    (grant_f),
      .cap_data   (mem_rdata),
      .can_accept (f_can),
      .rsp_valid  (f_rsp_valid),
      .rsp_ready  (f_rsp_ready),
      .rsp_rdata  (f_rsp_rdata)
   );

   imem_rsp_slot #(.DATA_W(DATA_W)) u_l_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .capture    (grant_l),
      .cap_data   (l_cap_data),
      .can_accept (l_can),
      .rsp_valid  (l_rsp_valid),
      .rsp_ready  (l_rsp_ready),
      .rsp_rdata  (l_rsp_rdata)
   );

`ifdef IMEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt    <= '0;
         fetch_stall_cnt <= '0;
      end else begin
         if (elig_f && elig_l && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + 32'd1;
         if (f_req_valid && !f_req_ready && fetch_stall_cnt != '1)
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed table-driven bench for imem_arbiter with a write-synchronous memory model.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
   logic [31:0] f_req_addr, f_rsp_rdata;
   logic        l_req_valid, l_req_ready, l_req_we, l_rsp_valid, l_rsp_ready;
   logic [31:0] l_req_addr, l_req_wdata, l_rsp_rdata;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata, mem_rdata;
`ifdef IMEM_ARB_STATS_EN
   logic [31:0] conflict_cnt, fetch_stall_cnt;
`endif

   logic [31:0] mem [0:4095];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

   imem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .f_req_valid (f_req_valid),
      .f_req_ready (f_req_ready),
      .f_req_addr  (f_req_addr),
      .f_rsp_valid (f_rsp_valid),
      .f_rsp_ready (f_rsp_ready),
      .f_rsp_rdata (f_rsp_rdata),
      .l_req_valid (l_req_valid),
      .l_req_ready (l_req_ready),
      .l_req_we    (l_req_we),
      .l_req_addr  (l_req_addr),
      .l_req_wdata (l_req_wdata),
      .l_rsp_valid (l_rsp_valid),
      .l_rsp_ready (l_rsp_ready),
      .l_rsp_rdata (l_rsp_rdata),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
`ifdef IMEM_ARB_STATS_EN
      ,
      .conflict_cnt    (conflict_cnt),
      .fetch_stall_cnt (fetch_stall_cnt)
`endif
   );

   typedef struct {
      logic        fv;  logic [31:0] fa;  logic frr;
      logic        lv;  logic lwe; logic [31:0] la; logic [31:0] lwd; logic lrr;
      logic        e_fr; logic e_lr; logic [31:0] e_ma; logic e_we;
      logic        e_fv; logic [31:0] e_fd; logic e_lv; logic [31:0] e_ld;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fv, input logic [31:0] fa, input logic frr,
                        input logic lv, input logic lwe, input logic [31:0] la,
                        input logic [31:0] lwd, input logic lrr);
      f_req_valid = fv; f_req_addr = fa; f_rsp_ready = frr;
      l_req_valid = lv; l_req_we = lwe; l_req_addr = la;
      l_req_wdata = lwd; l_rsp_ready = lrr;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + i;
      mem[4] = 32'hDEAD_BEEF;

      //            fv fa          frr lv lwe la        lwd           lrr  fr lr ma we  fv fd            lv ld
      vecs[0]  = '{1, 32'h10,   1, 1, 0, 32'h08, 32'h0,        1,   1, 0, 4, 0,  1, 32'hDEADBEEF, 0, 32'h0};
      vecs[1]  = '{1, 32'h10,   1, 1, 0, 32'h08, 32'h0,        1,   0, 1, 2, 0,  0, 32'h0,        1, 32'hA0000002};
      vecs[2]  = '{1, 32'h10,   1, 1, 0, 32'h08, 32'h0,        1,   1, 0, 4, 0,  1, 32'hDEADBEEF, 0, 32'h0};
      vecs[3]  = '{1, 32'h10,   1, 1, 0, 32'h08, 32'h0,        1,   0, 1, 2, 0,  0, 32'h0,        1, 32'hA0000002};
      vecs[4]  = '{0, 32'h0,    1, 1, 1, 32'h20, 32'h12345678, 1,   0, 1, 8, 1,  0, 32'h0,        1, 32'h0};
      vecs[5]  = '{1, 32'h20,   1, 0, 0, 32'h0,  32'h0,        1,   1, 0, 8, 0,  1, 32'h12345678, 0, 32'h0};
      vecs[6]  = '{1, 32'h4004, 1, 0, 0, 32'h0,  32'h0,        1,   1, 0, 1, 0,  1, 32'hA0000001, 0, 32'h0};
      vecs[7]  = '{1, 32'h7,    1, 0, 0, 32'h0,  32'h0,        1,   1, 0, 1, 0,  1, 32'hA0000001, 0, 32'h0};
      vecs[8]  = '{0, 32'h0,    1, 0, 0, 32'h0,  32'h0,        1,   0, 0, 1, 0,  0, 32'h0,        0, 32'h0};
      vecs[9]  = '{1, 32'h10,   0, 0, 0, 32'h0,  32'h0,        1,   1, 0, 4, 0,  1, 32'hDEADBEEF, 0, 32'h0};
      vecs[10] = '{1, 32'h04,   0, 1, 0, 32'h08, 32'h0,        1,   0, 1, 2, 0,  1, 32'hDEADBEEF, 1, 32'hA0000002};
      vecs[11] = '{1, 32'h04,   1, 0, 0, 32'h0,  32'h0,        1,   1, 0, 1, 0,  1, 32'hA0000001, 0, 32'h0};

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset f_rsp_valid", {31'b0, f_rsp_valid}, 32'd0);
      chk("reset l_rsp_valid", {31'b0, l_rsp_valid}, 32'd0);
      chk("reset f_rsp_rdata", f_rsp_rdata, 32'd0);
      chk("reset l_rsp_rdata", l_rsp_rdata, 32'd0);
      chk("reset mem_addr", {20'b0, mem_addr}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].fv, vecs[i].fa, vecs[i].frr, vecs[i].lv, vecs[i].lwe,
               vecs[i].la, vecs[i].lwd, vecs[i].lrr);
         @(negedge clk);
         chk($sformatf("v%0d f_req_ready", i), {31'b0, f_req_ready}, {31'b0, vecs[i].e_fr});
         chk($sformatf("v%0d l_req_ready", i), {31'b0, l_req_ready}, {31'b0, vecs[i].e_lr});
         chk($sformatf("v%0d mem_addr", i), {20'b0, mem_addr}, vecs[i].e_ma);
         chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_we});
         @(posedge clk) #1;
         chk($sformatf("v%0d f_rsp_valid", i), {31'b0, f_rsp_valid}, {31'b0, vecs[i].e_fv});
         chk($sformatf("v%0d l_rsp_valid", i), {31'b0, l_rsp_valid}, {31'b0, vecs[i].e_lv});
         if (vecs[i].e_fv) chk($sformatf("v%0d f_rsp_rdata", i), f_rsp_rdata, vecs[i].e_fd);
         if (vecs[i].e_lv) chk($sformatf("v%0d l_rsp_rdata", i), l_rsp_rdata, vecs[i].e_ld);
      end

      // Loader read left unconsumed, then a fetch so last_grant points at fetch before reset.
      drive(0, 0, 1, 1, 0, 32'h0C, 0, 0);
      @(negedge clk);
      chk("s1 l_req_ready", {31'b0, l_req_ready}, 32'd1);
      @(posedge clk) #1;
      chk("s1 l_rsp_rdata", l_rsp_rdata, 32'hA000_0003);
      drive(1, 32'h10, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("s2 f_req_ready", {31'b0, f_req_ready}, 32'd1);
      @(posedge clk) #1;
      chk("s2 l_rsp_valid held", {31'b0, l_rsp_valid}, 32'd1);
      chk("s2 l_rsp_rdata held", l_rsp_rdata, 32'hA000_0003);

      // Asynchronous reset between edges with both requesters active.
      drive(1, 32'h10, 1, 1, 0, 32'h08, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("areset l_rsp_valid", {31'b0, l_rsp_valid}, 32'd0);
      chk("areset f_rsp_valid", {31'b0, f_rsp_valid}, 32'd0);
      chk("areset l_rsp_rdata", l_rsp_rdata, 32'd0);
      chk("areset f_req_ready", {31'b0, f_req_ready}, 32'd0);
      chk("areset l_req_ready", {31'b0, l_req_ready}, 32'd0);
      chk("areset mem_addr", {20'b0, mem_addr}, 32'd0);
      chk("areset mem_we", {31'b0, mem_we}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("post-reset f_req_ready", {31'b0, f_req_ready}, 32'd1);
      chk("post-reset l_req_ready", {31'b0, l_req_ready}, 32'd0);
      chk("post-reset mem_addr", {20'b0, mem_addr}, 32'd4);
      @(posedge clk) #1;
      chk("post-reset f_rsp_valid", {31'b0, f_rsp_valid}, 32'd1);
      chk("post-reset f_rsp_rdata", f_rsp_rdata, 32'hDEAD_BEEF);
      chk("post-reset l_rsp_valid", {31'b0, l_rsp_valid}, 32'd0);

      drive(0, 0, 1, 0, 0, 0, 0, 1);
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
